// File: rtl/multicycle_cpu_core.sv
// Multi-cycle 16-bit-encoding CPU core with generic data width, one shared
// req/ack memory port, an 8-entry register file and a retired-instruction counter.
module multicycle_cpu_core #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                CNT_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [2:0]        state_o,
   output logic              retire_o,
   output logic [CNT_W-1:0]  retire_count_o
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [2:0] OP_R = 3'd0, OP_ADDI = 3'd1, OP_LW = 3'd2, OP_SW = 3'd3;
   localparam logic [2:0] OP_BEQ = 3'd4, OP_BNE = 3'd5, OP_LI = 3'd6, OP_J = 3'd7;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d, tgt_q, tgt_d, addr_q, addr_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, wdata_q, wdata_d;
   logic              req_q, req_d, we_q, we_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] regs_q [8];
   logic [DATA_W-1:0] regs_d [8];

   logic              retire, go_fetch;
   logic [ADDR_W-1:0] npc, boff, jaddr;
   logic [2:0]        op, rs, rt, rd, dest;
   logic [3:0]        funct;
   logic [6:0]        imm7;
   logic [DATA_W-1:0] sext, zext, ea;

   function automatic logic [DATA_W-1:0] alu_r(input logic [3:0] f,
                                               input logic signed [DATA_W-1:0] x,
                                               input logic signed [DATA_W-1:0] y);
      case (f)
         4'd0:    return x + y;
         4'd1:    return x - y;
         4'd2:    return x & y;
         4'd3:    return x | y;
         4'd4:    return (x < y) ? DATA_W'(1) : '0;
         4'd5:    return $unsigned(x) << y[3:0];
         4'd6:    return $unsigned(x) >> y[3:0];
         default: return '0;
      endcase
   endfunction

   assign op    = ir_q[15:13];
   assign rs    = ir_q[12:10];
   assign rt    = ir_q[9:7];
   assign rd    = ir_q[6:4];
   assign funct = ir_q[3:0];
   assign imm7  = ir_q[6:0];
   assign dest  = (op == OP_R) ? rd : rt;
   assign sext  = {{(DATA_W-7){imm7[6]}}, imm7};
   assign zext  = {{(DATA_W-7){1'b0}}, imm7};
   assign ea    = a_q + sext;
   assign boff  = {{(ADDR_W-8){imm7[6]}}, imm7, 1'b0};
   // pc_q already holds PC+2 once the instruction has been fetched
   assign jaddr = (pc_q & ~ADDR_W'(14'h3FFF)) | ADDR_W'({ir_q[12:0], 1'b0});

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ipc_d    = ipc_q;
      tgt_d    = tgt_q;
      addr_d   = addr_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      wdata_d  = wdata_q;
      req_d    = req_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      regs_d   = regs_q;
      retire   = 1'b0;
      go_fetch = 1'b0;
      npc      = pc_q;
      case (state_q)
         S_FETCH: begin
            if (!req_q) begin
               req_d  = 1'b1;
               addr_d = pc_q;
               ipc_d  = pc_q;
            end else if (mem_ack_i) begin
               ir_d    = mem_rdata_i[15:0];
               pc_d    = pc_q + ADDR_W'(2);
               req_d   = 1'b0;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = regs_q[rs];
            b_d     = regs_q[rt];
            tgt_d   = pc_q + boff;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (op)
               OP_LW, OP_SW: begin
                  addr_d  = ADDR_W'(ea);
                  wdata_d = b_q;
                  req_d   = 1'b1;
                  we_d    = (op == OP_SW);
                  state_d = S_MEM;
               end
               OP_BEQ, OP_BNE: begin
                  npc      = ((a_q == b_q) == (op == OP_BEQ)) ? tgt_q : pc_q;
                  retire   = 1'b1;
                  go_fetch = 1'b1;
               end
               OP_J: begin
                  npc      = jaddr;
                  retire   = 1'b1;
                  go_fetch = 1'b1;
               end
               OP_ADDI: begin res_d = ea;   state_d = S_WB; end
               OP_LI:   begin res_d = zext; state_d = S_WB; end
               default: begin res_d = alu_r(funct, a_q, b_q); state_d = S_WB; end
            endcase
         end
         S_MEM: begin
            if (req_q && mem_ack_i) begin
               we_d = 1'b0;
               if (op == OP_SW) begin
                  retire   = 1'b1;
                  go_fetch = 1'b1;
               end else begin
                  req_d   = 1'b0;
                  res_d   = mem_rdata_i;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            if (dest != 3'd0) regs_d[dest] = res_q;
            retire   = 1'b1;
            go_fetch = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      // Issue the next fetch straight from the retiring cycle so it has no idle gap
      if (go_fetch) begin
         state_d = S_FETCH;
         pc_d    = npc;
         ipc_d   = npc;
         addr_d  = npc;
         req_d   = 1'b1;
         we_d    = 1'b0;
      end
      if (retire) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ipc_q   <= RESET_PC;
         tgt_q   <= '0;
         addr_q  <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         wdata_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         tgt_q   <= tgt_d;
         addr_q  <= addr_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         wdata_q <= wdata_d;
         req_q   <= req_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
         regs_q  <= regs_d;
      end
   end

   assign mem_req_o      = req_q;
   assign mem_we_o       = we_q;
   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = wdata_q;
   assign pc_o           = ipc_q;
   assign state_o        = state_q;
   assign retire_o       = retire & ~rst_i;
   assign retire_count_o = cnt_q;

endmodule
